// File: rtl/jam_cost_table.sv
// Cost matrix store for the job-assignment engine: streamed row-major load, then zero-latency lookup.
// Optional row-minimum lower bound is enabled by defining JAM_COST_ROW_MIN_EN.
module jam_cost_table #(
  parameter int N  = 8,
  parameter int CW = 7
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [CW-1:0] in_data,
  input  logic          reload,
  input  logic [2:0]    W,
  input  logic [2:0]    J,
  output logic [CW-1:0] Cost,
  output logic [6:0]    load_count,
  output logic          table_ready,
  output logic          jam_rst,
  output logic [9:0]    lower_bound
);

  localparam int ENTRIES = N * N;
  localparam int AW      = $clog2(ENTRIES);
  localparam int CB      = $clog2(N);

  typedef enum logic {S_LOAD, S_SERVE} state_e;

  state_e        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [CW-1:0] mem [ENTRIES];
  logic          accept;

  assign accept = (state_q == S_LOAD) && in_valid;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_LOAD: if (in_valid) begin
        cnt_d = cnt_q + 7'd1;
        if (cnt_q == 7'(ENTRIES - 1)) state_d = S_SERVE;
      end
      S_SERVE: if (reload) begin
        state_d = S_LOAD;
        cnt_d   = '0;
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == S_LOAD);
    table_ready = (state_q == S_SERVE);
    jam_rst     = (state_q != S_SERVE);
    load_count  = cnt_q;
    // Engine samples Cost one cycle after driving W/J, so no read register here
    Cost        = (state_q == S_SERVE) ? mem[{W, J}] : '0;
  end

  // Storage is deliberately not reset; a new load overwrites it
  always_ff @(posedge CLK) begin
    if (accept) mem[cnt_q[AW-1:0]] <= in_data;
  end

`ifdef JAM_COST_ROW_MIN_EN
  logic [CW-1:0] min_q, min_d, row_min;
  logic [9:0]    acc_q, acc_d;
  logic          row_first, row_last;

  assign row_first = (cnt_q[CB-1:0] == '0);
  assign row_last  = (cnt_q[CB-1:0] == CB'(N - 1));

  always_comb begin
    row_min = (row_first || (in_data < min_q)) ? in_data : min_q;
    min_d   = accept ? row_min : min_q;
    acc_d   = acc_q;
    if (accept && row_last) acc_d = acc_q + 10'(row_min);
    if ((state_q == S_SERVE) && reload) acc_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      min_q <= '0;
      acc_q <= '0;
    end else begin
      min_q <= min_d;
      acc_q <= acc_d;
    end
  end

  assign lower_bound = acc_q;
`else
  assign lower_bound = '0;
`endif

endmodule

// File: doc/jam_cost_table.md
Name: jam_cost_table

Overview:
- Upstream stage of the job-assignment search engine.
- Accepts the 8x8 worker/job cost matrix as a streamed load (valid/ready), stores it, then serves zero-latency Cost lookups addressed by the engine's W/J outputs.
- Holds the search engine in reset (jam_rst) until a complete matrix is loaded; a reload request re-arms loading for a new problem.

Parameters:
- N, 8, workers and jobs per side; matrix holds N*N entries.
- CW, 7, cost entry width in bits.

Ports:
- CLK  input  1  clock; all state changes on rising edge.
- RST  input  1  synchronous, active-high reset.
- in_valid  input  1  load stream: in_data is valid.
- in_ready  output  1  load stream: table accepts an entry this cycle.
- in_data  input  CW  cost entry, row-major order (entry k = worker k/N, job k%N).
- reload  input  1  single-cycle request to discard the table and load a new one.
- W  input  3  worker index from the search engine.
- J  input  3  job index from the search engine.
- Cost  output  CW  cost of (W,J); combinational read.
- load_count  output  7  number of entries accepted in the current load, 0..64.
- table_ready  output  1  table is complete and being served.
- jam_rst  output  1  reset to the search engine; high while no valid table exists.
- lower_bound  output  10  sum of row minima (see Optional Feature).

Behaviour:
- Synchronous, active-high reset. On reset: state=LOAD, load_count=0, table_ready=0, jam_rst=1, in_ready=1, lower_bound=0. Memory contents are not cleared.
- State LOAD:
  - in_ready=1.
  - An entry is accepted on any edge with in_valid=1. It is written to mem[load_count] and load_count increments.
  - On the 64th accept (load_count==63 && in_valid), the next state is SERVE.
  - While in LOAD, Cost=0 regardless of W/J.
  - reload is ignored.
- State SERVE:
  - in_ready=0; in_valid is ignored and writes nothing.
  - table_ready=1 and jam_rst=0 from the first SERVE cycle, i.e. the cycle after the 64th accept (registered outputs).
  - load_count holds at 64.
  - Cost = mem[W*8+J], purely combinational with no registered stage. The engine drives W/J from registers and samples Cost one cycle later, so this read is required to be zero-latency.
- Reload:
  - reload=1 in SERVE moves the block to LOAD on the next edge.
  - On that edge: load_count=0, table_ready=0, jam_rst=1, in_ready=1, lower_bound=0.
  - An in_valid present in the same cycle as reload is not accepted.
- Reset mid-load: load restarts from entry 0. Partially written data is overwritten by the new load.
- Back-to-back accepts: one entry per cycle is sustained for all 64 entries. No bubbles are required.
- Widths: load_count is 7 bits and saturates at 64 (no wrap). W*8+J forms a 6-bit address.
- State encoding is two states (LOAD, SERVE), held in one register, plus the counter.

Optional Feature:
- Macro: JAM_COST_ROW_MIN_EN.
- Defined:
  - During LOAD, a CW-bit running minimum tracks the current row; it is initialised with the first entry of each row.
  - On each row's 8th accept, the row minimum is added to a 10-bit accumulator. Maximum is 8*127=1016, so there is no overflow.
  - lower_bound shows the accumulator. It is final and stable from the first SERVE cycle, and is cleared by reset or reload.
  - The engine or testbench uses it as the theoretical cost floor.
- Undefined: the port still exists and is driven constant 0. No min/accumulator logic is synthesized.

Test Plan:
- Reset, then stream 64 entries k -> k+1 (values 1..64) with in_valid held high -> in_ready high for exactly 64 cycles. table_ready and jam_rst=0 rise on cycle 65. W=2,J=5 gives Cost=22; W=7,J=7 gives Cost=64.
- Same load with in_valid toggled every other cycle -> load_count increments only on valid cycles. SERVE is entered one cycle after the 64th accepted entry. No entry is lost or duplicated.
- Query W=0,J=0 during LOAD -> Cost=0. After load, sweep all 64 (W,J) -> Cost equals the stored value in the same cycle.
- In SERVE, assert reload together with in_valid and in_data=99 -> next cycle jam_rst=1, table_ready=0, load_count=0. mem[0] is not overwritten by 99 until a later accept.
- Assert RST after 30 accepts -> load_count=0, jam_rst=1. A fresh full load then completes normally, and entry 0 holds the new value.
- With JAM_COST_ROW_MIN_EN: row r entries are r*10+j+3 for j=0..7 -> lower_bound = sum over r of (r*10+3) = 304. Without the macro, lower_bound=0.
